// File: rtl/button_conditioner.sv
// Conditions the raw start/pause/cheat push-buttons into clean game-flow controls.
// Each channel: synchroniser -> debounce -> press detect, then a small control FSM.
//
// state  | meaning
// IDLE   | waiting for the first start press
// RUN    | game running, cheat presses pulse cheatN
// PAUSED | game paused, pause press resumes
// ENDED  | game over/won, only reset leaves
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic resetN,
  input  logic key_startN,
  input  logic key_pauseN,
  input  logic key_cheatN,
  input  logic game_end,
  output logic start_game,
  output logic pause,
  output logic cheatN
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, ENDED} state_t;

  // channel index: 0 = start, 1 = pause, 2 = cheat
  logic [2:0]             raw;
  logic [2:0]             synced;
  logic [2:0]             stable_q;
  logic [2:0]             stable_prev_q;
  logic [2:0]             press;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [CW-1:0]          cnt_q  [3];

  assign raw = {key_cheatN, key_pauseN, key_startN};

  always_comb begin
    synced = '1;
    for (int ch = 0; ch < 3; ch++) synced[ch] = sync_q[ch][SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int ch = 0; ch < 3; ch++) begin
        sync_q[ch] <= '1;
        cnt_q[ch]  <= '0;
      end
      stable_q      <= '1;
      stable_prev_q <= '1;
    end else begin
      stable_prev_q <= stable_q;
      for (int ch = 0; ch < 3; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
        if (synced[ch] == stable_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          stable_q[ch] <= synced[ch];
          cnt_q[ch]    <= '0;
        end else begin
          cnt_q[ch] <= cnt_q[ch] + CW'(1);
        end
      end
    end
  end

  // One cycle after the stable level falls; releases never produce an event.
  assign press = stable_prev_q & ~stable_q;

  state_t state_q, state_d;
  logic   start_d, pause_d, cheat_n_d;

  always_comb begin
    state_d   = state_q;
    cheat_n_d = 1'b1;
    case (state_q)
      IDLE:   if (press[0]) state_d = RUN;
      RUN: begin
        if (game_end)      state_d = ENDED;
        else if (press[1]) state_d = PAUSED;
        else if (press[2]) cheat_n_d = 1'b0;
      end
      PAUSED: begin
        if (game_end)      state_d = ENDED;
        else if (press[1]) state_d = RUN;
      end
      ENDED:  state_d = ENDED;
      default: state_d = IDLE;
    endcase
    start_d = (state_d != IDLE);
    pause_d = (state_d == PAUSED);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      start_game <= 1'b0;
      pause      <= 1'b0;
      cheatN     <= 1'b1;
    end else begin
      state_q    <= state_d;
      start_game <= start_d;
      pause      <= pause_d;
      cheatN     <= cheat_n_d;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Expected {start_game, pause, cheatN} per cycle are queued, then popped and compared.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic resetN, key_startN, key_pauseN, key_cheatN, game_end;
  logic start_game, pause, cheatN;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q [$];

  button_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .resetN(resetN),
    .key_startN(key_startN), .key_pauseN(key_pauseN), .key_cheatN(key_cheatN),
    .game_end(game_end),
    .start_game(start_game), .pause(pause), .cheatN(cheatN)
  );

  always #5 clk = ~clk;

  // Push n expected triples, then run n cycles popping one per cycle at the falling edge.
  task automatic expect_n(input string tag, input int n, input logic s, input logic p, input logic c);
    logic [2:0] exp_v, got_v;
    for (int i = 0; i < n; i++) exp_q.push_back({s, p, c});
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = {start_game, pause, cheatN};
      checks++;
      assert (got_v === exp_v) else begin
        failures++;
        $error("FAIL %s cycle %0d: got start/pause/cheatN=%b expected %b", tag, i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    resetN = 1'b0; key_startN = 1'b1; key_pauseN = 1'b1; key_cheatN = 1'b1; game_end = 1'b0;
    expect_n("reset_hold", 3, 0, 0, 1);
    resetN = 1'b1;
    expect_n("idle", 20, 0, 0, 1);

    key_pauseN = 1'b0; key_cheatN = 1'b0;
    expect_n("idle_ignores", 15, 0, 0, 1);
    key_pauseN = 1'b1; key_cheatN = 1'b1;
    expect_n("idle_release", 10, 0, 0, 1);

    key_startN = 1'b0;
    expect_n("start_lat", 6, 0, 0, 1);
    expect_n("start_rise", 1, 1, 0, 1);
    expect_n("start_hold", 5, 1, 0, 1);
    key_startN = 1'b1;
    expect_n("start_release", 10, 1, 0, 1);
    key_startN = 1'b0;
    expect_n("start_again", 10, 1, 0, 1);
    key_startN = 1'b1;
    expect_n("start_again_rel", 10, 1, 0, 1);

    for (int g = 0; g < 5; g++) begin
      key_pauseN = 1'b0;
      expect_n("glitch_low", 3, 1, 0, 1);
      key_pauseN = 1'b1;
      expect_n("glitch_high", 3, 1, 0, 1);
    end
    expect_n("glitch_settle", 6, 1, 0, 1);

    key_pauseN = 1'b0;
    expect_n("pause_lat", 6, 1, 0, 1);
    expect_n("pause_on", 1, 1, 1, 1);
    expect_n("pause_hold", 3, 1, 1, 1);
    key_pauseN = 1'b1;
    expect_n("pause_release", 10, 1, 1, 1);
    key_pauseN = 1'b0;
    expect_n("resume_lat", 6, 1, 1, 1);
    expect_n("resume", 1, 1, 0, 1);
    key_pauseN = 1'b1;
    expect_n("resume_release", 10, 1, 0, 1);

    key_cheatN = 1'b0;
    expect_n("cheat_lat", 6, 1, 0, 1);
    expect_n("cheat_pulse", 1, 1, 0, 0);
    expect_n("cheat_hold", 43, 1, 0, 1);
    key_cheatN = 1'b1;
    expect_n("cheat_release", 10, 1, 0, 1);

    key_pauseN = 1'b0;
    expect_n("pause2_lat", 6, 1, 0, 1);
    expect_n("pause2_on", 1, 1, 1, 1);
    key_pauseN = 1'b1;
    expect_n("pause2_release", 10, 1, 1, 1);
    key_cheatN = 1'b0;
    expect_n("cheat_paused", 20, 1, 1, 1);
    key_cheatN = 1'b1;
    expect_n("cheat_paused_rel", 10, 1, 1, 1);

    game_end = 1'b1;
    expect_n("end_from_pause", 1, 1, 0, 1);
    game_end = 1'b0;
    expect_n("ended", 5, 1, 0, 1);
    key_pauseN = 1'b0;
    expect_n("ended_pause", 15, 1, 0, 1);
    key_pauseN = 1'b1;
    key_cheatN = 1'b0;
    expect_n("ended_cheat", 15, 1, 0, 1);
    key_cheatN = 1'b1;
    key_startN = 1'b0;
    expect_n("ended_start", 15, 1, 0, 1);
    key_startN = 1'b1;
    expect_n("ended_release", 10, 1, 0, 1);

    resetN = 1'b0;
    expect_n("reset_pulse", 2, 0, 0, 1);
    resetN = 1'b1;
    expect_n("after_reset", 10, 0, 0, 1);

    key_startN = 1'b0;
    expect_n("start2_lat", 6, 0, 0, 1);
    expect_n("start2_rise", 1, 1, 0, 1);
    key_startN = 1'b1;
    expect_n("start2_release", 10, 1, 0, 1);
    key_pauseN = 1'b0; key_cheatN = 1'b0;
    expect_n("both_lat", 6, 1, 0, 1);
    expect_n("both_pause_wins", 1, 1, 1, 1);
    expect_n("both_hold", 5, 1, 1, 1);
    key_pauseN = 1'b1; key_cheatN = 1'b1;
    expect_n("both_release", 10, 1, 1, 1);

    key_startN = 1'b0;
    resetN = 1'b0;
    expect_n("held_reset", 2, 0, 0, 1);
    resetN = 1'b1;
    expect_n("held_lat", 6, 0, 0, 1);
    expect_n("held_start", 1, 1, 0, 1);
    key_startN = 1'b1;
    expect_n("held_release", 10, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
